mash_ddsm_param: RTL and testbench

- Parametrised, runtime-reconfigurable MASH digital delta-sigma modulator, successor to the fixed 16-bit MASH-1-1-1 block.
- Accumulator width and integer width are parameters; modulator order (1, 2 or 3) is selectable at runtime.
- Integer/fractional/order words load through a valid/ready handshake: hitless when order is unchanged, via a short flush FSM when order changes.
- Feeds the fractional-N divider control; output is a registered, saturated integer division word.

---
 rtl/mash_ddsm_param.sv | 244 ++++++++++++++++++++++++
 tb/tb_mash_ddsm_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mash_ddsm_param.sv
`default_nettype none
// ============================================================================
// Module   : mash_ddsm_param
// Brief    : Runtime-reconfigurable MASH 1/1-1/1-1-1 delta-sigma modulator
//            producing a registered, saturated integer division word for a
//            fractional-N divider. Config words load over valid/ready; an
//            order change passes through a two-cycle flush.
// Options  : define MASH_DDSM_DITHER_EN to add LFSR carry-in dither on the
//            first accumulator stage.
// Revision : 1.0 - initial release
// ============================================================================
module mash_ddsm_param #(
  parameter int ACC_W     = 16,
  parameter int INT_W     = 4,
  parameter int MAX_ORDER = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [INT_W-1:0] cfg_int,
  input  logic [ACC_W-1:0] cfg_frac,
  input  logic [1:0]       cfg_order,
  output logic [INT_W-1:0] out,
  output logic             out_valid,
  output logic             sat
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [1:0]       C_MAX_ORDER = 2'(MAX_ORDER);
  localparam logic [INT_W-1:0] C_OUT_MAX   = {INT_W{1'b1}};

  // FSM and configuration
  state_t             state_q, state_d;
  logic               flush_cnt_q, flush_cnt_d;
  logic               cfg_loaded_q, cfg_loaded_d;
  logic [INT_W-1:0]   int_q, int_d;
  logic [ACC_W-1:0]   frac_q, frac_d;
  logic [1:0]         order_q, order_d;
  logic               cfg_accept;
  logic [1:0]         order_req;

  // Accumulators: the MSB of each register holds the carry produced by the
  // previous update, so it doubles as the first carry delay stage.
  logic [ACC_W:0]     acc1_q, acc1_d;
  logic [ACC_W:0]     acc2_q, acc2_d;
  logic [ACC_W:0]     acc3_q, acc3_d;
  logic               c1_d2_q, c1_d2_d;
  logic               c2_d2_q, c2_d2_d;
  logic               c3_d2_q, c3_d2_d;
  logic [INT_W-1:0]   int_dl1_q, int_dl1_d;
  logic [INT_W-1:0]   int_dl2_q, int_dl2_d;

  // Output registers
  logic [INT_W-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               sat_q, sat_d;

  // Datapath intermediates
  logic               cin;
  logic [ACC_W:0]     sum1, sum2, sum3;
  logic [ACC_W:0]     stage2, stage3;
  logic               c1, c2, c3;
  logic [3:0]         f;
  logic [INT_W-1:0]   int_al;
  logic [INT_W+1:0]   sum_w;

  assign cfg_ready = (state_q != ST_FLUSH);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sat       = sat_q;

  // Config acceptance, order clamping and next-state selection
  always_comb begin
    cfg_accept   = cfg_valid && (state_q != ST_FLUSH);
    order_req    = ((cfg_order == 2'd0) || (cfg_order > C_MAX_ORDER)) ? C_MAX_ORDER : cfg_order;
    int_d        = cfg_accept ? cfg_int   : int_q;
    frac_d       = cfg_accept ? cfg_frac  : frac_q;
    order_d      = cfg_accept ? order_req : order_q;
    cfg_loaded_d = cfg_loaded_q | cfg_accept;
    state_d      = state_q;
    flush_cnt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run && (cfg_accept || cfg_loaded_q)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!run)             state_d = ST_IDLE;
        else if (flush_cnt_q) state_d = ST_RUN;
        else                  flush_cnt_d = 1'b1;
      end
      ST_RUN: begin
        // run low wins over an order change arriving on the same edge
        if (!run)                                        state_d = ST_IDLE;
        else if (cfg_accept && (order_req != order_q))   state_d = ST_FLUSH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifdef MASH_DDSM_DITHER_EN
  logic [14:0] lfsr_q, lfsr_d;
  localparam logic [14:0] C_LFSR_SEED = 15'h0001;

  // Dither LFSR steps only while modulating and restarts from the seed otherwise
  always_comb begin
    lfsr_d = C_LFSR_SEED;
    if ((state_q == ST_RUN) && (state_d == ST_RUN))
      lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
  end

  // Dither LFSR register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= C_LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign cin = lfsr_q[0];
`else
  assign cin = 1'b0;
`endif

  // Accumulator cascade, noise cancellation and saturating output stage
  always_comb begin
    sum1   = {1'b0, acc1_q[ACC_W-1:0]} + {1'b0, frac_q} + {{ACC_W{1'b0}}, cin};
    sum2   = {1'b0, acc2_q[ACC_W-1:0]} + {1'b0, acc1_q[ACC_W-1:0]};
    sum3   = {1'b0, acc3_q[ACC_W-1:0]} + {1'b0, acc2_q[ACC_W-1:0]};
    stage2 = (order_q >= 2'd2) ? sum2 : '0;
    stage3 = (order_q == 2'd3) ? sum3 : '0;
    c1     = sum1[ACC_W];
    c2     = stage2[ACC_W];
    c3     = stage3[ACC_W];

    // 4-bit two's-complement arithmetic; results stay within -3..4
    case (order_q)
      2'd1:    f = {3'b000, c1};
      2'd2:    f = {3'b000, acc1_q[ACC_W]} + {3'b000, c2} - {3'b000, acc2_q[ACC_W]};
      default: f = {3'b000, c1_d2_q} + {3'b000, acc2_q[ACC_W]} - {3'b000, c2_d2_q}
                 + {3'b000, c3} - {2'b00, acc3_q[ACC_W], 1'b0} + {3'b000, c3_d2_q};
    endcase

    // Integer word delayed by order-1 cycles to line up with the carry path
    case (order_q)
      2'd1:    int_al = int_q;
      2'd2:    int_al = int_dl1_q;
      default: int_al = int_dl2_q;
    endcase

    sum_w = {2'b00, int_al} + {{(INT_W-2){f[3]}}, f};

    acc1_d      = '0;
    acc2_d      = '0;
    acc3_d      = '0;
    c1_d2_d     = 1'b0;
    c2_d2_d     = 1'b0;
    c3_d2_d     = 1'b0;
    int_dl1_d   = int_d;
    int_dl2_d   = int_d;
    out_d       = '0;
    out_valid_d = 1'b0;
    sat_d       = 1'b0;

    if (state_d == ST_RUN) begin
      acc1_d      = sum1;
      acc2_d      = stage2;
      acc3_d      = stage3;
      c1_d2_d     = acc1_q[ACC_W];
      c2_d2_d     = acc2_q[ACC_W];
      c3_d2_d     = acc3_q[ACC_W];
      int_dl1_d   = int_q;
      int_dl2_d   = int_dl1_q;
      out_valid_d = 1'b1;
      if (sum_w[INT_W+1]) begin
        out_d = '0;
        sat_d = 1'b1;
      end else if (sum_w[INT_W]) begin
        out_d = C_OUT_MAX;
        sat_d = 1'b1;
      end else begin
        out_d = sum_w[INT_W-1:0];
      end
    end else if (state_d == ST_FLUSH) begin
      // Flush presents the plain integer word; the delay line is prefilled
      // with it so the first modulated word is already aligned.
      out_d = int_d;
    end
  end

  // Configuration, accumulator, delay-line and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_loaded_q <= 1'b0;
      int_q        <= '0;
      frac_q       <= '0;
      order_q      <= C_MAX_ORDER;
      acc1_q       <= '0;
      acc2_q       <= '0;
      acc3_q       <= '0;
      c1_d2_q      <= 1'b0;
      c2_d2_q      <= 1'b0;
      c3_d2_q      <= 1'b0;
      int_dl1_q    <= '0;
      int_dl2_q    <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      cfg_loaded_q <= cfg_loaded_d;
      int_q        <= int_d;
      frac_q       <= frac_d;
      order_q      <= order_d;
      acc1_q       <= acc1_d;
      acc2_q       <= acc2_d;
      acc3_q       <= acc3_d;
      c1_d2_q      <= c1_d2_d;
      c2_d2_q      <= c2_d2_d;
      c3_d2_q      <= c3_d2_d;
      int_dl1_q    <= int_dl1_d;
      int_dl2_q    <= int_dl2_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      sat_q        <= sat_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mash_ddsm_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mash_ddsm_param
// Brief    : Self-checking bench for mash_ddsm_param (ACC_W=8, INT_W=4,
//            MAX_ORDER=3) with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mash_ddsm_param;
  localparam int AW   = 8;
  localparam int IW   = 4;
  localparam int MO   = 3;
  localparam int MOD  = 256;
  localparam int OMAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [IW-1:0] cfg_int = '0;
  logic [AW-1:0] cfg_frac = '0;
  logic [1:0]    cfg_order = '0;
  logic          cfg_ready;
  logic [IW-1:0] out;
  logic          out_valid;
  logic          sat;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mash_ddsm_param #(.ACC_W(AW), .INT_W(IW), .MAX_ORDER(MO)) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_order(cfg_order),
    .out(out), .out_valid(out_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec arithmetic on integers) ----------
  int m_state = 0;               // 0 idle, 1 flush, 2 run
  int m_fcnt  = 0;
  bit m_loaded = 1'b0;
  int m_int = 0, m_frac = 0, m_order = MO;
  int m_acc [1:3];
  int m_ch  [1:3][1:2];          // carry history: [k][1]=one cycle ago, [k][2]=two
  int m_past[0:2];               // integer word 0/1/2 edges ago
  int exp_out = 0;
  bit exp_valid = 1'b0, exp_sat = 1'b0;
  int t_acc, t_eo, t_nxt, t_cnt, t_ni, t_nf, t_no;
  int s1, s2, s3, c1, c2, c3, t_f, t_sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_fcnt = 0; m_loaded = 1'b0;
      m_int = 0; m_frac = 0; m_order = MO;
      for (int k = 1; k <= 3; k++) begin m_acc[k] = 0; m_ch[k][1] = 0; m_ch[k][2] = 0; end
      for (int k = 0; k <= 2; k++) m_past[k] = 0;
      exp_out = 0; exp_valid = 1'b0; exp_sat = 1'b0;
    end else begin
      t_acc = (cfg_valid && m_state != 1) ? 1 : 0;
      t_eo  = (cfg_order == 0 || int'(cfg_order) > MO) ? MO : int'(cfg_order);
      t_nxt = m_state;
      t_cnt = 0;
      case (m_state)
        0: if (run && (t_acc == 1 || m_loaded)) t_nxt = 1;
        1: if (!run) t_nxt = 0; else if (m_fcnt == 1) t_nxt = 2; else t_cnt = m_fcnt + 1;
        default: if (!run) t_nxt = 0; else if (t_acc == 1 && t_eo != m_order) t_nxt = 1;
      endcase
      t_ni = (t_acc == 1) ? int'(cfg_int)  : m_int;
      t_nf = (t_acc == 1) ? int'(cfg_frac) : m_frac;
      t_no = (t_acc == 1) ? t_eo           : m_order;
      if (t_nxt == 2) begin
        s1 = m_acc[1] + m_frac;
        s2 = (m_order >= 2) ? m_acc[2] + m_acc[1] : 0;
        s3 = (m_order >= 3) ? m_acc[3] + m_acc[2] : 0;
        c1 = s1 / MOD; c2 = s2 / MOD; c3 = s3 / MOD;
        if (m_order == 1)      t_f = c1;
        else if (m_order == 2) t_f = m_ch[1][1] + c2 - m_ch[2][1];
        else t_f = m_ch[1][2] + m_ch[2][1] - m_ch[2][2] + c3 - 2 * m_ch[3][1] + m_ch[3][2];
        t_sum = m_past[m_order - 1] + t_f;
        exp_sat   = (t_sum < 0 || t_sum > OMAX);
        exp_out   = (t_sum < 0) ? 0 : ((t_sum > OMAX) ? OMAX : t_sum);
        exp_valid = 1'b1;
        m_acc[1] = s1 % MOD; m_acc[2] = s2 % MOD; m_acc[3] = s3 % MOD;
        m_ch[1][2] = m_ch[1][1]; m_ch[1][1] = c1;
        m_ch[2][2] = m_ch[2][1]; m_ch[2][1] = c2;
        m_ch[3][2] = m_ch[3][1]; m_ch[3][1] = c3;
        m_past[2] = m_past[1]; m_past[1] = m_past[0]; m_past[0] = t_ni;
      end else begin
        for (int k = 1; k <= 3; k++) begin m_acc[k] = 0; m_ch[k][1] = 0; m_ch[k][2] = 0; end
        for (int k = 0; k <= 2; k++) m_past[k] = t_ni;
        exp_out   = (t_nxt == 1) ? t_ni : 0;
        exp_valid = 1'b0;
        exp_sat   = 1'b0;
      end
      m_state = t_nxt; m_fcnt = t_cnt;
      m_int = t_ni; m_frac = t_nf; m_order = t_no;
      if (t_acc == 1) m_loaded = 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out",       int'(out),       exp_out);
      check("model_out_valid", int'(out_valid), int'(exp_valid));
      check("model_sat",       int'(sat),       int'(exp_sat));
      check("model_cfg_ready", int'(cfg_ready), (m_state != 1) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_cfg(input int i_v, input int f_v, input int o_v);
    cfg_int   = IW'(i_v);
    cfg_frac  = AW'(f_v);
    cfg_order = 2'(o_v);
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && k < 12) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(out_valid), 1);
  endtask

  int acc_sum, nbad, nsat, v;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", int'(out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_sat", int'(sat), 0);
    check("reset_cfg_ready", int'(cfg_ready), 1);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // integer-only word: two flush cycles then constant 7
    run = 1'b1;
    send_cfg(7, 0, 3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("a_flush_ready", int'(cfg_ready), 0);
      check("a_flush_valid", int'(out_valid), 0);
      check("a_flush_out", int'(out), 7);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("a_run_valid", int'(out_valid), 1);
      check("a_run_out", int'(out), 7);
      check("a_run_sat", int'(sat), 0);
    end

    // order change 3 -> 2 goes through flush
    send_cfg(9, 0, 2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("oc_flush_ready", int'(cfg_ready), 0);
      check("oc_flush_valid", int'(out_valid), 0);
      check("oc_flush_out", int'(out), 9);
    end
    @(negedge clk);
    check("oc_run_valid", int'(out_valid), 1);
    check("oc_run_out", int'(out), 9);

    // hitless update at order 2: new integer appears on the second edge
    send_cfg(3, 0, 2);
    @(negedge clk);
    check("hl_edge0_out", int'(out), 9);
    check("hl_edge0_ready", int'(cfg_ready), 1);
    @(negedge clk);
    check("hl_edge1_out", int'(out), 9);
    @(negedge clk);
    check("hl_edge2_out", int'(out), 3);

    // order 1, frac 1/2: alternating 5/6, exact mean over 256 cycles
    send_cfg(5, 128, 1);
    wait_valid("b_wait_valid");
    acc_sum = 0;
    for (int i = 0; i < 256; i++) begin
      v = int'(out);
      acc_sum += v;
      if (i < 4) check("b_pattern", v, (i % 2 == 1) ? 6 : 5);
      @(negedge clk);
    end
    check("b_sum256", acc_sum, 5 * 256 + 128);

    // order 3, frac 37/256: range and long-run mean
    send_cfg(6, 37, 3);
    wait_valid("c_wait_valid");
    acc_sum = 0; nbad = 0;
    for (int i = 0; i < 2048; i++) begin
      v = int'(out);
      acc_sum += v;
      if (v < 3 || v > 10) nbad++;
      @(negedge clk);
    end
    check("c_range_violations", nbad, 0);
    check("c_sum_in_band", (acc_sum >= 12584 - 4 && acc_sum <= 12584 + 4) ? 1 : acc_sum, 1);

    // low clamp
    send_cfg(1, 200, 3);
    wait_valid("d_wait_valid");
    nsat = 0;
    for (int i = 0; i < 1000; i++) begin
      if (sat) begin
        nsat++;
        check("d_low_clamp_out", int'(out), 0);
      end
      @(negedge clk);
    end
    check("d_low_sat_seen", (nsat > 0) ? 1 : 0, 1);

    // high clamp (hitless, same order); let the old word drain first
    send_cfg(14, 200, 3);
    repeat (4) @(negedge clk);
    nsat = 0;
    for (int i = 0; i < 500; i++) begin
      if (sat) begin
        nsat++;
        check("d_high_clamp_out", int'(out), OMAX);
      end
      @(negedge clk);
    end
    check("d_high_sat_seen", (nsat > 0) ? 1 : 0, 1);

    // asynchronous reset in the middle of RUN
    #2 rst = 1'b1;
    #1;
    check("e_async_out", int'(out), 0);
    check("e_async_out_valid", int'(out_valid), 0);
    check("e_async_sat", int'(sat), 0);
    check("e_async_cfg_ready", int'(cfg_ready), 1);
    #4 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("e_stay_idle_valid", int'(out_valid), 0);
      check("e_stay_idle_out", int'(out), 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) run = ~run;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_int   = IW'($urandom_range(0, 15));
      cfg_frac  = AW'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) cfg_order = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
